// File: rtl/regfile_rd_sequencer.sv
// regfile_rd_sequencer: serialises a two-operand read onto one regfile read port, forwarding in-flight writes.
// Optional RFSEQ_SAME_ADDR_SKIP_EN: when ra==rb, skip the second read (IDLE->RD_A->RESP).
module regfile_rd_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_ra,
  input  logic [ADDR_WIDTH-1:0] req_rb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_a,
  output logic [DATA_WIDTH-1:0] rsp_b,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wadr,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic [ADDR_WIDTH-1:0] rf_radr,
  input  logic [DATA_WIDTH-1:0] rf_dout
);
  typedef enum logic [1:0] {IDLE, RD_A, RD_B, RESP} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] ra, rb;
  logic hit_a, hit_b, skip;
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;
  assign rf_we = wb_valid & reset;
  assign rf_wadr = wb_adr;
  assign rf_din = wb_data;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign hit_a = wb_valid && wb_adr == ra;
  assign hit_b = wb_valid && wb_adr == rb;
  // a write committing on the capture edge has not reached rf_dout yet
  assign fwd_a = hit_a ? wb_data : rf_dout;
  assign fwd_b = hit_b ? wb_data : rf_dout;
`ifdef RFSEQ_SAME_ADDR_SKIP_EN
  assign skip = ra == rb;
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    state_nx = state == IDLE ? (req_valid ? RD_A : IDLE) :
               state == RD_A ? (skip ? RESP : RD_B) :
               state == RD_B ? RESP :
               (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      rf_radr <= '0;
      rsp_a <= '0;
      rsp_b <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (req_valid) begin
          ra <= req_ra;
          rb <= req_rb;
          rf_radr <= req_ra;
        end
        RD_A: begin
          rsp_a <= fwd_a;
          rf_radr <= rb;
          if (skip) rsp_b <= fwd_a;
        end
        RD_B: begin
          rsp_b <= fwd_b;
          if (hit_a) rsp_a <= wb_data;
        end
        RESP: if (!rsp_ready) begin
          // the handshake edge delivers pre-edge values, so snooping stops there
          if (hit_a) rsp_a <= wb_data;
          if (hit_b) rsp_b <= wb_data;
        end
        default: ;
      endcase
    end
  end
endmodule
